// File: rtl/tcp_pkg.sv
// tcp_pkg: state encodings, flag bit positions and composite flag constants
// shared by the TCP connection controller and its bench-facing outputs.
package tcp_pkg;

  typedef enum logic [2:0] {
    ST_CLOSED      = 3'd0,
    ST_LISTEN      = 3'd1,
    ST_SYN_RCVD    = 3'd2,
    ST_ESTABLISHED = 3'd3,
    ST_CLOSE_WAIT  = 3'd4,
    ST_LAST_ACK    = 3'd5
  } tcp_state_e;

  // Bit positions inside the {URG,ACK,PSH,RST,SYN,FIN} flag vector
  localparam int unsigned FL_FIN_B = 0;
  localparam int unsigned FL_SYN_B = 1;
  localparam int unsigned FL_RST_B = 2;
  localparam int unsigned FL_PSH_B = 3;
  localparam int unsigned FL_ACK_B = 4;
  localparam int unsigned FL_URG_B = 5;

  localparam logic [5:0] FL_ACK    = 6'b01_0000;
  localparam logic [5:0] FL_SYNACK = 6'b01_0010;
  localparam logic [5:0] FL_FINACK = 6'b01_0001;

endpackage

// File: rtl/tcp_retx_timer.sv
// tcp_retx_timer: retransmit interval counter plus retry counter.
// expire_o is combinational so the controller can act on it in the same cycle.
module tcp_retx_timer #(
  parameter logic [23:0] RETX_CYCLES = 24'd1_250_000,
  parameter logic [2:0]  MAX_RETRY   = 3'd3
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic run_i,
  input  logic retry_clr_i,
  input  logic retry_inc_i,
  output logic expire_o,
  output logic retry_max_o
);

  logic [23:0] cnt_q;
  logic [2:0]  retry_q;

  assign expire_o    = run_i && (cnt_q == RETX_CYCLES - 24'd1);
  assign retry_max_o = (retry_q == MAX_RETRY);

  // Interval counter: restart on load, advance only while running
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt_q <= '0;
    else if (load_i) cnt_q <= '0;
    else if (run_i)  cnt_q <= cnt_q + 24'd1;
  end

  // Retry counter: cleared when a new wait phase begins, bumped per resend
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              retry_q <= '0;
    else if (retry_clr_i) retry_q <= '0;
    else if (retry_inc_i) retry_q <= retry_q + 3'd1;
  end

endmodule

// File: rtl/tcp_conn_ctrl.sv
// tcp_conn_ctrl: single-connection passive-open TCP controller. Consumes
// parsed receive segments, tracks rcv_nxt/snd_nxt, flags payload accept/drop
// and issues one control segment at a time over a req/ack handshake.
module tcp_conn_ctrl
  import tcp_pkg::*;
#(
  parameter logic [15:0] LOCAL_PORT  = 16'd80,
  parameter logic [31:0] ISS         = 32'h0000_1000,
  parameter logic [23:0] RETX_CYCLES = 24'd1_250_000,
  parameter logic [2:0]  MAX_RETRY   = 3'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        seg_valid_i,
  input  logic [15:0] seg_src_port_i,
  input  logic [15:0] seg_dst_port_i,
  input  logic [31:0] seg_seq_i,
  input  logic [31:0] seg_ack_i,
  input  logic [5:0]  seg_flags_i,
  input  logic [15:0] seg_len_i,
  input  logic        seg_crc_ok_i,
  input  logic        close_req_i,
  output logic        tx_req_o,
  input  logic        tx_ack_i,
  output logic [5:0]  tx_flags_o,
  output logic [31:0] tx_seq_o,
  output logic [31:0] tx_ack_num_o,
  output logic [15:0] tx_dst_port_o,
  output logic        data_accept_o,
  output logic        seg_drop_o,
  output logic [2:0]  state_o
);

  tcp_state_e  state_q, state_d;
  logic [31:0] rcv_q, rcv_d, snd_q, snd_d;
  logic [15:0] rport_q, rport_d;
  logic        tx_req_q, tx_req_d;
  logic [5:0]  tx_flags_q, tx_flags_d;
  logic [31:0] tx_seq_q, tx_seq_d, tx_ackn_q, tx_ackn_d;
  logic [15:0] tx_port_q, tx_port_d;
  logic        acc_q, acc_d, drop_q, drop_d, pend_q, pend_d;

  logic        tmr_load, tmr_run, tmr_exp, retry_max, retx, est_seg;
  logic        seg_bad, seq_ok;
  logic [31:0] seq_adv;
  logic        unused_flags;

  assign unused_flags = ^{seg_flags_i[FL_PSH_B], seg_flags_i[FL_URG_B]};

  // Outstanding tx request blocks new segments so tx fields never change mid-handshake
  assign seg_bad = !seg_crc_ok_i || (seg_dst_port_i != LOCAL_PORT) || tx_req_q ||
                   ((state_q != ST_LISTEN) && (seg_src_port_i != rport_q));
  assign seq_ok  = (seg_seq_i == rcv_q);
  assign seq_adv = rcv_q + {16'd0, seg_len_i} + {31'd0, seg_flags_i[FL_FIN_B]};

  assign tmr_run  = ((state_q == ST_SYN_RCVD) || (state_q == ST_LAST_ACK)) && !tx_req_q;
  assign tmr_load = (state_d != state_q) || retx || (seg_valid_i && tmr_exp);

  tcp_retx_timer #(.RETX_CYCLES(RETX_CYCLES), .MAX_RETRY(MAX_RETRY)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .load_i      (tmr_load),
    .run_i       (tmr_run),
    .retry_clr_i (state_d != state_q),
    .retry_inc_i (retx),
    .expire_o    (tmr_exp),
    .retry_max_o (retry_max)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLOSED;  rcv_q <= '0;  snd_q <= '0;  rport_q <= '0;
      tx_req_q <= 1'b0;  tx_flags_q <= '0;  tx_seq_q <= '0;  tx_ackn_q <= '0;
      tx_port_q <= '0;  acc_q <= 1'b0;  drop_q <= 1'b0;  pend_q <= 1'b0;
    end else begin
      state_q <= state_d;  rcv_q <= rcv_d;  snd_q <= snd_d;  rport_q <= rport_d;
      tx_req_q <= tx_req_d;  tx_flags_q <= tx_flags_d;  tx_seq_q <= tx_seq_d;
      tx_ackn_q <= tx_ackn_d;  tx_port_q <= tx_port_d;
      acc_q <= acc_d;  drop_q <= drop_d;  pend_q <= pend_d;
    end
  end

  // Next-state: connection FSM, sequence tracking and tx request generation
  always_comb begin
    state_d    = state_q;  rcv_d = rcv_q;  snd_d = snd_q;  rport_d = rport_q;
    tx_req_d   = tx_req_q & ~tx_ack_i;
    tx_flags_d = tx_flags_q;  tx_seq_d = tx_seq_q;  tx_ackn_d = tx_ackn_q;
    tx_port_d  = tx_port_q;
    acc_d = 1'b0;  drop_d = 1'b0;  pend_d = pend_q;  retx = 1'b0;  est_seg = 1'b0;
    case (state_q)
      ST_CLOSED: begin
        if (en_i) state_d = ST_LISTEN;
        drop_d = seg_valid_i;
      end
      ST_LISTEN: begin
        if (!en_i) begin
          state_d = ST_CLOSED;
          drop_d  = seg_valid_i;
        end else if (seg_valid_i) begin
          if (!seg_bad && seg_flags_i[FL_SYN_B] && !seg_flags_i[FL_ACK_B] && !seg_flags_i[FL_RST_B]) begin
            state_d = ST_SYN_RCVD;  rport_d = seg_src_port_i;
            rcv_d   = seg_seq_i + 32'd1;  snd_d = ISS;
            tx_req_d = 1'b1;  tx_flags_d = FL_SYNACK;  tx_seq_d = ISS;
            tx_ackn_d = seg_seq_i + 32'd1;  tx_port_d = seg_src_port_i;
          end else drop_d = 1'b1;
        end
      end
      ST_SYN_RCVD: begin
        if (seg_valid_i) begin
          if (seg_bad) drop_d = 1'b1;
          else if (seg_flags_i[FL_RST_B]) state_d = ST_LISTEN;
          else if (seg_flags_i[FL_ACK_B] && (seg_ack_i == ISS + 32'd1) && seq_ok) begin
            snd_d = ISS + 32'd1;  state_d = ST_ESTABLISHED;  est_seg = 1'b1;
          end else drop_d = 1'b1;
        end else if (tmr_exp) begin
          if (retry_max) state_d = ST_LISTEN;
          else begin
            retx = 1'b1;  tx_req_d = 1'b1;  tx_flags_d = FL_SYNACK;
            tx_seq_d = ISS;  tx_ackn_d = rcv_q;
          end
        end
      end
      ST_ESTABLISHED: begin
        if (seg_valid_i) begin
          if (seg_bad) drop_d = 1'b1;
          else est_seg = 1'b1;
        end
      end
      ST_CLOSE_WAIT: begin
        drop_d = seg_valid_i & seg_bad;
        // A close that arrives while tx is busy is parked until the request clears
        if ((close_req_i || pend_q) && !tx_req_q) begin
          state_d = ST_LAST_ACK;  pend_d = 1'b0;  snd_d = snd_q + 32'd1;
          tx_req_d = 1'b1;  tx_flags_d = FL_FINACK;  tx_seq_d = snd_q;  tx_ackn_d = rcv_q;
        end else if (close_req_i) pend_d = 1'b1;
      end
      ST_LAST_ACK: begin
        if (seg_valid_i) begin
          if (!seg_bad && seg_flags_i[FL_ACK_B] && (seg_ack_i == snd_q)) state_d = ST_LISTEN;
          else drop_d = 1'b1;
        end else if (tmr_exp) begin
          if (retry_max) state_d = ST_LISTEN;
          else begin
            retx = 1'b1;  tx_req_d = 1'b1;  tx_flags_d = FL_FINACK;
            tx_seq_d = snd_q - 32'd1;  tx_ackn_d = rcv_q;
          end
        end
      end
      default: state_d = ST_CLOSED;
    endcase
    // Established-state segment handling, shared with the ACK that completes the handshake
    if (est_seg) begin
      if (seg_flags_i[FL_RST_B]) begin
        if (seq_ok) state_d = ST_LISTEN;
        else drop_d = 1'b1;
      end else if (seq_ok) begin
        acc_d = (seg_len_i != 16'd0);
        if (seg_flags_i[FL_FIN_B] || (seg_len_i != 16'd0)) begin
          rcv_d = seq_adv;  tx_req_d = 1'b1;  tx_flags_d = FL_ACK;
          tx_seq_d = snd_d;  tx_ackn_d = seq_adv;
        end
        if (seg_flags_i[FL_FIN_B]) state_d = ST_CLOSE_WAIT;
      end else if (seg_flags_i[FL_FIN_B] || (seg_len_i != 16'd0)) begin
        drop_d = 1'b1;  tx_req_d = 1'b1;  tx_flags_d = FL_ACK;
        tx_seq_d = snd_d;  tx_ackn_d = rcv_q;
      end
    end
  end

  // Outputs come straight from registers
  always_comb begin
    tx_req_o      = tx_req_q;
    tx_flags_o    = tx_flags_q;
    tx_seq_o      = tx_seq_q;
    tx_ack_num_o  = tx_ackn_q;
    tx_dst_port_o = tx_port_q;
    data_accept_o = acc_q;
    seg_drop_o    = drop_q;
    state_o       = state_q;
  end

endmodule

// File: doc/tcp_conn_ctrl.md
Name: tcp_conn_ctrl

Overview:
- Single-connection TCP passive-open controller, fed by the receive-side transport layer (parsed header fields plus checksum result) after each segment.
- Runs the connection state machine, validates sequence/ack numbers and tracks rcv_nxt/snd_nxt.
- Decides accept/drop for the payload.
- Sequences the transmit side by issuing one control-segment request at a time (SYN|ACK, ACK, FIN|ACK) over a req/ack handshake.

Parameters:
- LOCAL_PORT, 16'd80, only destination port served.
- ISS, 32'h0000_1000, initial send sequence number.
- RETX_CYCLES, 24'd1_250_000, retransmit timeout in clk cycles (10 ms at 125 MHz).
- MAX_RETRY, 3'd3, retransmissions before abandoning to LISTEN.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- en_i  in  1  listen enable.
- seg_valid_i  in  1  one-cycle pulse; all seg_* fields stable in that cycle.
- seg_src_port_i  in  16  remote port.
- seg_dst_port_i  in  16  local port.
- seg_seq_i  in  32  sequence number.
- seg_ack_i  in  32  acknowledgement number.
- seg_flags_i  in  6  {URG,ACK,PSH,RST,SYN,FIN}.
- seg_len_i  in  16  payload bytes (packet length minus header length*4).
- seg_crc_ok_i  in  1  checksum folded sum == 16'hFFFF.
- close_req_i  in  1  application close pulse.
- tx_req_o  out  1  transmit request, level.
- tx_ack_i  in  1  one-cycle pulse, segment taken.
- tx_flags_o  out  6  flags of the requested segment.
- tx_seq_o  out  32  sequence field.
- tx_ack_num_o  out  32  acknowledgement field.
- tx_dst_port_o  out  16  remote port.
- data_accept_o  out  1  pulse: payload of the last segment is in-order; deliver it.
- seg_drop_o  out  1  pulse: segment rejected.
- state_o  out  3  current state.

Behaviour:
- Reset values: all outputs 0. State CLOSED; rcv_nxt, snd_nxt, remote_port, retry and timer all 0.
- State encoding: CLOSED=0, LISTEN=1, SYN_RCVD=2, ESTABLISHED=3, CLOSE_WAIT=4, LAST_ACK=5.
- Latency: state, data_accept_o/seg_drop_o and tx_req_o all update on the first clk edge after seg_valid_i; one cycle fixed.
- Handshake:
  - tx_req_o stays high with tx_* fields frozen until tx_ack_i; it drops on the edge that samples tx_ack_i.
  - tx_ack_i without tx_req_o is ignored.
- Gating:
  - A segment is dropped (seg_drop_o) if seg_crc_ok_i=0, dst port != LOCAL_PORT, or tx_req_o=1.
  - Outside LISTEN it is also dropped if src port != remote_port.
- Arithmetic: all sequence math is 32-bit modulo 2^32. SYN and FIN each consume 1.
- CLOSED: moves to LISTEN when en_i=1. All segments are dropped.
- LISTEN:
  - en_i=0 moves to CLOSED.
  - SYN=1, ACK=0, RST=0:
    - Latch remote_port.
    - rcv_nxt=seq+1; snd_nxt=ISS.
    - Request SYN|ACK with seq=ISS, ack=rcv_nxt.
    - Start the timer, retry=0, go to SYN_RCVD.
  - Anything else is dropped.
- SYN_RCVD:
  - ACK with ack==ISS+1 and seq==rcv_nxt: snd_nxt=ISS+1, go to ESTABLISHED. Any payload in that segment is processed as in ESTABLISHED.
  - RST: go to LISTEN.
  - Timer expiry: re-request SYN|ACK and increment retry. When retry==MAX_RETRY at expiry, go to LISTEN instead.
- ESTABLISHED:
  - seq==rcv_nxt and len>0: pulse data_accept_o, rcv_nxt+=len, request ACK.
  - FIN set (in-order): rcv_nxt+=len+1, request ACK, go to CLOSE_WAIT. data_accept_o fires if len>0.
  - seq!=rcv_nxt with len>0 or FIN: pulse seg_drop_o, request duplicate ACK with ack=rcv_nxt.
  - RST with seq==rcv_nxt: go to LISTEN.
  - Pure in-order ACK, len=0: no response.
- CLOSE_WAIT: close_req_i requests FIN|ACK with seq=snd_nxt; snd_nxt+=1, start the timer, retry=0, go to LAST_ACK. If tx_req_o is busy, the close is held pending until tx_req_o is free.
- LAST_ACK:
  - ACK with ack==snd_nxt: go to LISTEN.
  - Timer expiry: resend FIN|ACK with seq=snd_nxt-1, using the SYN_RCVD retry rule.
- Timer:
  - Counts only in SYN_RCVD/LAST_ACK while tx_req_o=0.
  - Expiry at RETX_CYCLES-1.
  - Reloads on every state change and on retransmit.
- Simultaneous events:
  - seg_valid_i and timer expiry in the same cycle: the segment wins and the timer reloads.
  - tx_ack_i and seg_valid_i in the same cycle: the segment is dropped, because tx_req_o is still high.
- Reset mid-operation: immediate return to reset values. tx_req_o drops without waiting for tx_ack_i.

Decomposition:
- Package tcp_pkg holds:
  - state encodings;
  - flag bit indices FIN=0, SYN=1, RST=2, PSH=3, ACK=4, URG=5;
  - composite constants FL_SYNACK, FL_ACK, FL_FINACK.
- Sub-module tcp_retx_timer: load/enable/expire counter plus retry counter.

Test Plan:
- Handshake: en_i=1, SYN seq=32'h100 to port 80 → tx SYN|ACK seq=32'h1000 ack=32'h101. After tx_ack_i, ACK with seq=32'h101 and ack=32'h1001 → state_o=3.
- Data: in-order seq=32'h101 len=100 → data_accept_o pulse, ACK with ack=32'h165. Then seq=32'h200 len=10 → seg_drop_o, duplicate ACK with ack=32'h165.
- Close: FIN seq=32'h165 len=0 → ACK 32'h166, state 4. close_req_i → FIN|ACK seq=32'h1001. ACK with ack=32'h1002 → state 1.
- Retransmit: SYN, then no ACK for RETX_CYCLES → three SYN|ACK resends. The fourth expiry returns to LISTEN.
- Gating: bad checksum, wrong port, or segment while tx_req_o=1 → seg_drop_o pulse, no state change.
- Reset asserted with tx_req_o=1 in ESTABLISHED → tx_req_o=0 and state_o=0 immediately.
